// File: rtl/clk_div_pkg.sv
// Shared types and constants for the integer reference-clock divider.
package clk_div_pkg;

    localparam int unsigned RATIO_WD_DEFAULT = 8;
    localparam int unsigned BYPASS_RATIO     = 1;

    typedef enum logic {
        ST_BYPASS = 1'b0,
        ST_DIVIDE = 1'b1
    } div_state_t;

    // Length of the high phase for ratio n: ceil(n/2).
    function automatic int unsigned half_up(input int unsigned n);
        return (n + 1) >> 1;
    endfunction

endpackage

// File: rtl/clk_div_mux.sv
// Output clock mux with a registered select; kept standalone so a library
// clock-mux cell can be dropped in.
module clk_div_mux (
    input  logic ref_clk,
    input  logic div_clk,
    input  logic sel,
    output logic out_clk
);

    // Select the divided clock while dividing, the reference otherwise.
    assign out_clk = sel ? div_clk : ref_clk;

endmodule

// File: rtl/clk_div_int.sv
// Integer clock divider: latches the ratio once per output period and falls
// back to passing the reference clock through for ratios 0/1 or enable low.
module clk_div_int
    import clk_div_pkg::*;
#(
    parameter int unsigned RATIO_WD = RATIO_WD_DEFAULT
) (
    input  logic                i_ref_clk,
    input  logic                i_rst,
    input  logic                i_clk_en,
    input  logic [RATIO_WD-1:0] i_div_ratio,
    output logic                o_div_clk,
    output logic                o_div_active
);

    div_state_t          state;
    logic [RATIO_WD-1:0] act_ratio;
    logic [RATIO_WD-1:0] cnt;
    logic                div_q;
    logic                sel_div;

    logic [RATIO_WD-1:0] load_ratio;
    logic                load_div;
    logic [RATIO_WD-1:0] half_n;
    logic [RATIO_WD-1:0] cnt_inc;
    logic                at_boundary;

    // Ratio candidate for the next period and derived period bookkeeping.
    always_comb begin
        load_ratio  = i_clk_en ? i_div_ratio : RATIO_WD'(BYPASS_RATIO);
        load_div    = (load_ratio >= RATIO_WD'(2));
        half_n      = RATIO_WD'(half_up(32'(act_ratio)));
        cnt_inc     = cnt + RATIO_WD'(1);
        at_boundary = (cnt == (act_ratio - RATIO_WD'(1)));
    end

    // Divider state, ratio latch, period counter and divided-clock level.
    always_ff @(posedge i_ref_clk or posedge i_rst) begin
        if (i_rst) begin
            state     <= ST_BYPASS;
            act_ratio <= RATIO_WD'(BYPASS_RATIO);
            cnt       <= '0;
            div_q     <= 1'b0;
        end else begin
            case (state)
                ST_BYPASS: begin
                    act_ratio <= load_ratio;
                    cnt       <= '0;
                    if (load_div) begin
                        div_q <= 1'b1;
                        state <= ST_DIVIDE;
                    end
                end
                ST_DIVIDE: begin
                    if (!at_boundary) begin
                        cnt   <= cnt_inc;
                        div_q <= (cnt_inc < half_n);
                    end else begin
                        act_ratio <= load_ratio;
                        cnt       <= '0;
                        if (load_div) begin
                            div_q <= 1'b1;
                        end else begin
                            div_q <= 1'b0;
                            state <= ST_BYPASS;
                        end
                    end
                end
                default: begin
                    state <= ST_BYPASS;
                end
            endcase
        end
    end

    assign sel_div      = (state == ST_DIVIDE);
    assign o_div_active = sel_div;

    clk_div_mux u_mux (
        .ref_clk (i_ref_clk),
        .div_clk (div_q),
        .sel     (sel_div),
        .out_clk (o_div_clk)
    );

endmodule

// File: tb/tb_clk_div_int.sv
// Testbench for clk_div_int: period-pattern model plus directed scenarios.
module tb_clk_div_int;

    logic       clk;
    logic       rst;
    logic       en;
    logic [7:0] ratio;
    logic       div_clk;
    logic       div_active;

    int total = 0;
    int bad   = 0;

    clk_div_int #(.RATIO_WD(8)) dut (
        .i_ref_clk    (clk),
        .i_rst        (rst),
        .i_clk_en     (en),
        .i_div_ratio  (ratio),
        .o_div_clk    (div_clk),
        .o_div_active (div_active)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model: each divided period is a queue of per-cycle levels (ceil(N/2)
    // ones then zeros); a new ratio is sampled only when the queue runs dry.
    bit q[$];
    bit m_active  = 1'b0;
    bit m_bit     = 1'b0;
    bit m_started = 1'b0;
    int m_n       = 0;

    always @(posedge clk or posedge rst) begin
        int l;
        if (rst) begin
            q.delete();
            m_active  = 1'b0;
            m_bit     = 1'b0;
            m_started = 1'b0;
        end else begin
            m_started = 1'b0;
            if (q.size() == 0) begin
                l = en ? int'(ratio) : 1;
                if (l >= 2) begin
                    for (int k = 0; k < l; k++) q.push_back(k < (l + 1) / 2);
                    m_started = 1'b1;
                    m_n       = l;
                end
            end
            if (q.size() > 0) begin
                m_bit    = q.pop_front();
                m_active = 1'b1;
            end else begin
                m_active = 1'b0;
                m_bit    = 1'b0;
            end
        end
    end

    task automatic chk(input string name, input int got, input int exp);
        total++;
        if (got != exp) begin
            bad++;
            $display("FAIL %s: got=%0d exp=%0d at t=%0t", name, got, exp, $time);
        end
    endtask

    // Continuous comparison shortly after every clock edge.
    always begin
        @(clk);
        #1;
        chk("active", int'(div_active), int'(m_active));
        chk("div_clk", int'(div_clk), m_active ? int'(m_bit) : int'(clk));
    end

    // Wait (bounded) for the negedge following the edge that starts a period of n.
    task automatic wait_start(input int n);
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (m_started && m_n == n) found = 1'b1;
        end
        if (!found) begin
            bad++;
            total++;
            $display("FAIL wait_start: got=timeout exp=period_%0d", n);
        end
    endtask

    task automatic wait_bypass();
        bit found = 1'b0;
        for (int i = 0; i < 600 && !found; i++) begin
            @(negedge clk);
            if (!m_active) found = 1'b1;
        end
        if (!found) begin
            bad++;
            total++;
            $display("FAIL wait_bypass: got=timeout exp=bypass");
        end
    endtask

    initial begin
        logic [11:0] s;
        int ones;
        int zeros;

        rst = 1'b1; en = 1'b0; ratio = 8'd0;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_active", int'(div_active), 0);
        chk("rst_clk_low", int'(div_clk), 0);
        @(posedge clk); #1;
        chk("rst_clk_high", int'(div_clk), 1);

        // Ratio 4 from reset release: 2 high / 2 low, active from first edge.
        @(negedge clk);
        rst = 1'b0; en = 1'b1; ratio = 8'd4;
        s = '0;
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            s = {s[10:0], div_clk};
            if (i == 0) chk("r4_active_first", int'(div_active), 1);
        end
        chk("r4_pattern", int'(s[7:0]), 8'b1100_1100);

        // Ratio 5: 3 high / 2 low.
        ratio = 8'd5;
        wait_start(5);
        s = {11'd0, div_clk};
        for (int i = 1; i < 10; i++) begin
            @(negedge clk);
            s = {s[10:0], div_clk};
        end
        chk("r5_pattern", int'(s[9:0]), 10'b11100_11100);

        // Ratio 255: 128 high / 127 low.
        ratio = 8'd255;
        wait_start(255);
        ones = int'(div_clk); zeros = int'(!div_clk);
        for (int i = 1; i < 255; i++) begin
            @(negedge clk);
            if (div_clk) ones++; else zeros++;
        end
        chk("r255_high", ones, 128);
        chk("r255_low", zeros, 127);

        // Bypass cases: ratio 0, ratio 1, enable low with ratio 8.
        ratio = 8'd0;
        wait_bypass();
        repeat (6) @(negedge clk);
        chk("r0_active", int'(div_active), 0);
        ratio = 8'd1;
        repeat (6) @(negedge clk);
        chk("r1_active", int'(div_active), 0);
        en = 1'b0; ratio = 8'd8;
        repeat (6) @(negedge clk);
        chk("en0_active", int'(div_active), 0);
        @(posedge clk); #1;
        chk("en0_follow", int'(div_clk), 1);

        // Ratio 4 -> 8 written at cnt=1: the 4-period completes first.
        @(negedge clk);
        en = 1'b1; ratio = 8'd4;
        wait_start(4);
        s = {11'd0, div_clk};
        for (int i = 1; i < 12; i++) begin
            @(negedge clk);
            s = {s[10:0], div_clk};
            if (i == 1) ratio = 8'd8;
        end
        chk("r4to8_pattern", int'(s), 12'b1100_1111_0000);

        // Enable dropped at cnt=3 of ratio 8: period finishes, then bypass.
        wait_start(8);
        repeat (3) @(negedge clk);
        en = 1'b0;
        s = {11'd0, div_clk};
        for (int i = 1; i < 5; i++) begin
            @(negedge clk);
            s = {s[10:0], div_clk};
            chk("en_drop_still_active", int'(div_active), 1);
        end
        chk("en_drop_tail", int'(s[4:0]), 5'b10000);
        @(negedge clk);
        chk("en_drop_bypass", int'(div_active), 0);
        en = 1'b1;
        @(negedge clk);
        chk("en_raise_active", int'(div_active), 1);
        chk("en_raise_high", int'(div_clk), 1);

        // Reset pulsed at cnt=2 of ratio 6, then a fresh 3/3 period.
        ratio = 8'd6;
        wait_start(6);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_mid_active", int'(div_active), 0);
        repeat (2) @(negedge clk);
        rst = 1'b0;
        s = '0;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            s = {s[10:0], div_clk};
        end
        chk("r6_restart", int'(s[5:0]), 6'b111000);
        chk("r6_active", int'(div_active), 1);

        repeat (4) @(negedge clk);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
